// File: rtl/clause_dist_unit_v2_if.sv
// Bus interface for clause_dist_unit_v2.
// Groups the load, control, engine-queue and chosen-unit-clause signals so the
// distribution unit and its driver share one port bundle.
//   master : driver side (loads clauses, issues control pulses, reads grants)
//   slave  : distribution unit side
// Signals:
//   full_in            per-engine queue full flags
//   load_sig_in        write clause_in into the clause buffer
//   clause_in          clause to load
//   start_in           begin a distribution pass
//   rewind_in          replay the database from entry 0 (from DONE)
//   clear_in           discard the database and return to LOAD
//   bcast_mode_in      0 = round-robin, 1 = broadcast
//   chosen_uc_in       chosen unit-clause literal
//   chosen_uc_valid_in chosen unit-clause literal valid
//   clause_out         per-engine clause slots, slot i = [i*CLA_W +: CLA_W]
//   grant_out          per-engine slot valid
//   empty_out          no undistributed clauses remain in the current pass
//   done_out           unit is in DONE
//   overflow_out       sticky: a load was attempted with the buffer full
//   chosen_uc_out      registered chosen_uc_in
//   chosen_uc_valid_out registered chosen_uc_valid_in
interface clause_dist_unit_v2_if #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_W      = 48,
  parameter int LIT_W      = 8
);
  logic [NUM_ENGINE-1:0]       full_in;
  logic                        load_sig_in;
  logic [CLA_W-1:0]            clause_in;
  logic                        start_in;
  logic                        rewind_in;
  logic                        clear_in;
  logic                        bcast_mode_in;
  logic [LIT_W-1:0]            chosen_uc_in;
  logic                        chosen_uc_valid_in;
  logic [NUM_ENGINE*CLA_W-1:0] clause_out;
  logic [NUM_ENGINE-1:0]       grant_out;
  logic                        empty_out;
  logic                        done_out;
  logic                        overflow_out;
  logic [LIT_W-1:0]            chosen_uc_out;
  logic                        chosen_uc_valid_out;

  modport master (
    output full_in, load_sig_in, clause_in, start_in, rewind_in, clear_in,
           bcast_mode_in, chosen_uc_in, chosen_uc_valid_in,
    input  clause_out, grant_out, empty_out, done_out, overflow_out,
           chosen_uc_out, chosen_uc_valid_out
  );

  modport slave (
    input  full_in, load_sig_in, clause_in, start_in, rewind_in, clear_in,
           bcast_mode_in, chosen_uc_in, chosen_uc_valid_in,
    output clause_out, grant_out, empty_out, done_out, overflow_out,
           chosen_uc_out, chosen_uc_valid_out
  );
endinterface

// File: rtl/clause_dist_unit_v2.sv
// Clause distribution unit.
// Holds a clause database of up to DEPTH entries, loaded once, and streams it
// to NUM_ENGINE engine clause queues per pass, either round-robin (up to
// ISSUE_WIDTH clauses per cycle to distinct non-full engines) or broadcast
// (each clause to every engine once all engines have room). A pass can be
// replayed with rewind_in without reloading. The chosen unit-clause literal is
// forwarded through one register stage.
// Ports:
//   clock  system clock
//   reset  asynchronous active-high reset
//   bus    clause_dist_unit_v2_if slave modport (see interface file)
module clause_dist_unit_v2 #(
  parameter int NUM_ENGINE  = 4,
  parameter int DEPTH       = 64,
  parameter int CLA_W       = 48,
  parameter int LIT_W       = 8,
  parameter int ISSUE_WIDTH = 2
) (
  input logic                  clock,
  input logic                  reset,
  clause_dist_unit_v2_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = $clog2(NUM_ENGINE);

  typedef enum logic [1:0] {LOAD, DIST, DONE} state_t;

  state_t                      state_q;
  logic [PW-1:0]               cnt_q;
  logic [PW-1:0]               rdPtr_q;
  logic [PW-1:0]               rdPtr_d;
  logic [EW-1:0]               rrPtr_q;
  logic [EW-1:0]               rrPtr_d;
  logic                        mode_q;
  logic                        overflow_q;
  logic                        empty_q;
  logic [NUM_ENGINE-1:0]       grant_q;
  logic [NUM_ENGINE-1:0]       grant_d;
  logic [NUM_ENGINE*CLA_W-1:0] clauseOut_q;
  logic [NUM_ENGINE*CLA_W-1:0] clauseOut_d;
  logic [CLA_W-1:0]            clauseMem_q [DEPTH];
  logic [LIT_W-1:0]            ucLit_q;
  logic                        ucValid_q;

  int                          issued;
  int                          remaining;
  int                          eng;
  int                          lastEng;
  logic [EW-1:0]               engIdx;

  // Issue decision for the current DIST cycle. Round-robin walks the engines
  // circularly from rrPtr_q and hands consecutive clauses to the first eligible
  // engines; broadcast issues one clause only when no engine is full.
  always_comb begin
    grant_d     = '0;
    clauseOut_d = '0;
    rdPtr_d     = rdPtr_q;
    rrPtr_d     = rrPtr_q;
    issued      = 0;
    eng         = 0;
    lastEng     = 0;
    engIdx      = '0;
    remaining   = int'(cnt_q) - int'(rdPtr_q);
    if (state_q == DIST) begin
      if (mode_q) begin
        if (bus.full_in == '0 && remaining > 0) begin
          grant_d     = '1;
          clauseOut_d = {NUM_ENGINE{clauseMem_q[rdPtr_q[AW-1:0]]}};
          issued      = 1;
        end
      end else begin
        for (int j = 0; j < NUM_ENGINE; j++) begin
          eng    = (int'(rrPtr_q) + j) % NUM_ENGINE;
          engIdx = EW'(eng);
          if (!bus.full_in[engIdx] && issued < ISSUE_WIDTH && issued < remaining) begin
            grant_d[engIdx] = 1'b1;
            clauseOut_d[int'(engIdx)*CLA_W +: CLA_W] = clauseMem_q[AW'(int'(rdPtr_q) + issued)];
            issued  = issued + 1;
            lastEng = eng;
          end
        end
        if (issued > 0) begin
          rrPtr_d = EW'((lastEng + 1) % NUM_ENGINE);
        end
      end
      rdPtr_d = rdPtr_q + PW'(issued);
    end
  end

  // Clause buffer write port. A load into a full buffer is dropped here and
  // flagged as overflow by the control FSM.
  always_ff @(posedge clock) begin
    if (state_q == LOAD && bus.load_sig_in && !bus.clear_in && cnt_q != PW'(DEPTH)) begin
      clauseMem_q[cnt_q[AW-1:0]] <= bus.clause_in;
    end
  end

  // Control FSM with registered grant/clause/empty outputs. clear_in wins over
  // everything; grants default to zero so a grant only lasts one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      rdPtr_q     <= '0;
      rrPtr_q     <= '0;
      mode_q      <= 1'b0;
      overflow_q  <= 1'b0;
      empty_q     <= 1'b0;
      grant_q     <= '0;
      clauseOut_q <= '0;
    end else begin
      grant_q     <= '0;
      clauseOut_q <= '0;
      if (bus.clear_in) begin
        state_q    <= LOAD;
        cnt_q      <= '0;
        rdPtr_q    <= '0;
        overflow_q <= 1'b0;
        empty_q    <= 1'b1;
      end else begin
        case (state_q)
          LOAD: begin
            empty_q <= 1'b1;
            if (bus.load_sig_in) begin
              if (cnt_q == PW'(DEPTH)) begin
                overflow_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + PW'(1);
              end
            end
            if (bus.start_in && cnt_q != '0) begin
              state_q <= DIST;
              rdPtr_q <= '0;
              mode_q  <= bus.bcast_mode_in;
              empty_q <= 1'b0;
            end
          end
          DIST: begin
            grant_q     <= grant_d;
            clauseOut_q <= clauseOut_d;
            rdPtr_q     <= rdPtr_d;
            rrPtr_q     <= rrPtr_d;
            empty_q     <= (rdPtr_d == cnt_q);
            if (rdPtr_d == cnt_q) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            empty_q <= 1'b1;
            if (bus.rewind_in) begin
              state_q <= DIST;
              rdPtr_q <= '0;
              mode_q  <= bus.bcast_mode_in;
              empty_q <= 1'b0;
            end
          end
          default: state_q <= LOAD;
        endcase
      end
    end
  end

  // Chosen unit-clause forwarding stage, independent of the FSM and of clear_in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ucLit_q   <= '0;
      ucValid_q <= 1'b0;
    end else begin
      ucLit_q   <= bus.chosen_uc_in;
      ucValid_q <= bus.chosen_uc_valid_in;
    end
  end

  assign bus.grant_out           = grant_q;
  assign bus.clause_out          = clauseOut_q;
  assign bus.empty_out           = empty_q;
  assign bus.done_out            = (state_q == DONE);
  assign bus.overflow_out        = overflow_q;
  assign bus.chosen_uc_out       = ucLit_q;
  assign bus.chosen_uc_valid_out = ucValid_q;
endmodule
